// File: rtl/bsa_pkg.sv
// Shared definitions for the byte-serial adder sequencer: FSM state type,
// byte width and the byte-index width helper.
package bsa_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

    // Width of the byte index counter; at least one bit so the counter exists.
    function automatic int idx_width(input int nbytes);
        return (nbytes < 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/add8_rc.sv
// Combinational 8-bit ripple-carry adder: one full adder per bit,
// carry chained from bit 0 upward.
module add8_rc
    import bsa_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[BYTE_W];

endmodule

// File: rtl/byte_serial_add_seq.sv
// Byte-serial wide adder: captures two NBYTES-byte operands, feeds one byte
// pair per cycle (LSB first) through a single 8-bit ripple-carry adder and
// presents the assembled sum with a valid/ready handshake.
// Optional build macro BSA_SIGNED_OVF_EN adds the out_ovf port carrying the
// two's-complement overflow of the full-width add.
module byte_serial_add_seq
    import bsa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout
`ifdef BSA_SIGNED_OVF_EN
    ,
    output logic                     out_ovf
`endif
);

    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    bsa_state_t state_reg, state_next;

    logic [BYTE_W*NBYTES-1:0] a_reg, b_reg, sum_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic                     carry_reg;
    logic                     cout_reg;

    logic [BYTE_W-1:0] a_bytes [NBYTES];
    logic [BYTE_W-1:0] b_bytes [NBYTES];
    logic [BYTE_W-1:0] add_a, add_b, add_sum;
    logic              add_cout;
    logic              last_byte;

    // Slice the captured operands into byte lanes for the index mux.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign a_bytes[gi] = a_reg[gi*BYTE_W +: BYTE_W];
            assign b_bytes[gi] = b_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign add_a     = a_bytes[idx_reg];
    assign add_b     = b_bytes[idx_reg];
    assign last_byte = (idx_reg == LAST_IDX);

    add8_rc u_add8 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_byte) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, carry chaining between bytes and sum assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        sum_reg   <= '0;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_reg == IDX_W'(i)) sum_reg[i*BYTE_W +: BYTE_W] <= add_sum;
                    end
                    carry_reg <= add_cout;
                    // The index stops at the top byte instead of wrapping.
                    if (last_byte) cout_reg <= add_cout;
                    else           idx_reg  <= idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;

`ifdef BSA_SIGNED_OVF_EN
    logic ovf_reg;

    // Overflow = carry into the sign bit XOR carry out of it, taken on the top byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_byte) begin
            ovf_reg <= (add_a[BYTE_W-1] ^ add_b[BYTE_W-1] ^ add_sum[BYTE_W-1]) ^ add_cout;
        end
    end

    assign out_ovf = ovf_reg;
`endif

endmodule

// File: doc/byte_serial_add_seq.md
Name: byte_serial_add_seq

Overview:
- Sequencer that performs wide (NBYTES×8-bit) additions by feeding one byte pair per cycle into an 8-bit ripple-carry adder.
- Registers the carry between bytes and assembles the full sum.
- Sits directly upstream of, and wraps, the team's 8-bit adder datapath.
- Exposes valid/ready handshakes on operand input and result output.

Parameters:
- NBYTES, 4, number of 8-bit byte slices per operand (legal range 2..16).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands present on in_a/in_b/in_cin
- in_ready  output  1  block can accept operands
- in_a  input  8*NBYTES  operand A
- in_b  input  8*NBYTES  operand B
- in_cin  input  1  carry-in into byte 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  8*NBYTES  sum
- out_cout  output  1  carry-out of the most significant byte

Behaviour:
- Single clock domain. Reset is synchronous and active-low: on rst_n=0 at a rising edge:
  - state=IDLE, byte index=0, carry register=0
  - out_sum=0, out_cout=0, out_valid=0
  - in_ready=1 in the cycle following reset release
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_a, in_b and in_cin into operand registers, clear out_sum, set byte index=0, load carry register with in_cin, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, drive the adder with a=A[8i+7:8i], b=B[8i+7:8i], cin=carry register.
  - At the edge, write the sum byte into out_sum[8i+7:8i], load the carry register with the adder cout, and increment i.
  - When i==NBYTES-1, at that edge go to DONE and load out_cout with the adder cout.
- DONE:
  - out_valid=1, in_ready=0. out_sum and out_cout are held stable.
  - On out_ready=1, out_valid drops at the next edge and the state goes to IDLE.
- Latency: out_valid rises exactly NBYTES cycles after the accepting edge. Throughput is one operation per NBYTES+2 cycles minimum, with no back-to-back overlap.
- Arithmetic is unsigned modulo 2^(8*NBYTES); out_cout is the true carry out. Byte order is little-endian: byte 0 is the least significant.
- Operand registers are immune to input changes after capture. in_a/in_b/in_cin are ignored unless in IDLE with in_valid=1.
- Backpressure: DONE holds indefinitely while out_ready=0.
- out_ready asserted outside DONE has no effect. in_valid outside IDLE is not accepted and not queued.
- Reset mid-RUN or mid-DONE aborts the operation and the partial result is discarded. Outputs follow the reset values.
- Byte index counter width is clog2(NBYTES). It never wraps past NBYTES-1.

Optional Feature:
- Macro: BSA_SIGNED_OVF_EN.
- When defined:
  - Adds output port out_ovf (1 bit): two's-complement overflow of the full-width add, equal to carry into MSB XOR carry out of MSB.
  - The carry into MSB is taken inside the top byte as a7^b7^sum7 of the final adder step.
  - out_ovf is registered with out_cout, reset to 0, and valid only with out_valid.
- When undefined: the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bsa_pkg holds:
  - state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - BYTE_W=8 constant
  - a function computing index width from NBYTES
- One sub-module, add8_rc: the combinational 8-bit ripple-carry adder (a, b, cin -> sum, cout), instantiated once.
- Sequencing, registers and handshakes stay in byte_serial_add_seq.

Test Plan:
- NBYTES=4: A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid exactly 4 cycles after accept.
- A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0. in_ready stays 0 from accept until the DONE handshake.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_sum are stable. Change in_a during the hold -> the result is unchanged and not accepted.
- Reset asserted at the 2nd RUN cycle of A=0xFFFFFFFF+B=0xFFFFFFFF -> next cycle out_valid=0, out_sum=0, out_cout=0, in_ready=1. A new add of 1+2 -> out_sum=0x00000003.
- BSA_SIGNED_OVF_EN: A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_ovf=1, out_cout=0. A=0xFFFFFFFF, B=0x00000001 -> out_ovf=0, out_cout=1.
- NBYTES=2 parameter sweep: A=0x00FF, B=0x0001, cin=1 -> out_sum=0x0101, out_cout=0, latency 2 cycles.
